// File: rtl/switch_mcu_alu_defs.sv
// Shared definitions for the switch MCU immediate ALU: funct3 codes,
// sequencer states and the immediate bit that selects SRAI over SRLI.
package switch_mcu_alu_defs;

  localparam logic [2:0] F3_ADDI  = 3'b000;
  localparam logic [2:0] F3_SLLI  = 3'b001;
  localparam logic [2:0] F3_SLTI  = 3'b010;
  localparam logic [2:0] F3_SLTIU = 3'b011;
  localparam logic [2:0] F3_XORI  = 3'b100;
  localparam logic [2:0] F3_SRXI  = 3'b101;
  localparam logic [2:0] F3_ORI   = 3'b110;
  localparam logic [2:0] F3_ANDI  = 3'b111;

  // Immediate bit that turns a right shift into an arithmetic one
  localparam int SRAI_SEL_BIT = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WAIT = 2'd2,
    EXEC = 2'd3
  } state_t;

endpackage

// File: rtl/switch_mcu_alu_imm_dp.sv
// Combinational datapath of the immediate ALU: computes the I-type result
// from the latched funct3/immediate and the register value, and flags
// shift encodings whose upper immediate bits are not allowed.
module switch_mcu_alu_imm_dp
  import switch_mcu_alu_defs::*;
#(
  parameter int XLEN  = 32,
  parameter int IMM_W = 12,
  parameter int SHW   = $clog2(XLEN)
) (
  input  logic [2:0]       funct3,
  input  logic [IMM_W-1:0] imm,
  input  logic [XLEN-1:0]  rs1_val,
  output logic [XLEN-1:0]  result,
  output logic             illegal
);

  // Low immediate bits hold the shift amount; everything above must be
  // zero, except the single SRAI selector bit on right shifts.
  localparam logic [IMM_W-1:0] SHAMT_MASK = IMM_W'((1 << SHW) - 1);
  localparam logic [IMM_W-1:0] SRAI_SEL   = IMM_W'(1) << SRAI_SEL_BIT;

  logic [XLEN-1:0]  imm_sx;
  logic [SHW-1:0]   shamt;
  logic [IMM_W-1:0] imm_hi;

  assign imm_sx = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
  assign shamt  = imm[SHW-1:0];
  assign imm_hi = imm & ~SHAMT_MASK;

  // Select the operation result and decode illegal shift encodings
  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (funct3)
      F3_ADDI:  result = rs1_val + imm_sx;
      F3_SLTI:  result = {{(XLEN-1){1'b0}}, ($signed(rs1_val) < $signed(imm_sx))};
      F3_SLTIU: result = {{(XLEN-1){1'b0}}, (rs1_val < imm_sx)};
      F3_XORI:  result = rs1_val ^ imm_sx;
      F3_ORI:   result = rs1_val | imm_sx;
      F3_ANDI:  result = rs1_val & imm_sx;
      F3_SLLI: begin
        result  = rs1_val << shamt;
        illegal = (imm_hi != '0);
      end
      F3_SRXI: begin
        if (imm[SRAI_SEL_BIT]) begin
          result = XLEN'($signed(rs1_val) >>> shamt);
        end else begin
          result = rs1_val >> shamt;
        end
        illegal = (imm_hi != '0) && (imm_hi != SRAI_SEL);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/switch_mcu_alu_imm.sv
// I-type immediate ALU for the switch MCU. A small sequencer reads rs1
// through register-file port 1, waits out the read latency, then writes
// the result back and pulses done. Dropping in_en cancels an op silently.
module switch_mcu_alu_imm
  import switch_mcu_alu_defs::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int IMM_W  = 12,
  parameter int RD_LAT = 1,
  parameter int SHW    = $clog2(XLEN)
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_en,
  input  logic [2:0]        in_funct3,
  input  logic [IMM_W-1:0]  in_imm_type_i,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [XLEN-1:0]   in_rdata_1,
  output logic [REG_AW-1:0] out_raddr_1,
  output logic              out_ren_1,
  output logic [REG_AW-1:0] out_waddr,
  output logic              out_wen,
  output logic [XLEN-1:0]   out_wdata,
  output logic              out_busy,
  output logic              out_done,
  output logic              out_illegal
);

  localparam int CNT_W = 3;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [2:0]        funct3_q, funct3_nxt;
  logic [IMM_W-1:0]  imm_q, imm_nxt;
  logic [REG_AW-1:0] rd_q, rd_nxt;

  logic [REG_AW-1:0] raddr_nxt, waddr_nxt;
  logic              ren_nxt, wen_nxt, busy_nxt, done_nxt, illegal_nxt;
  logic [XLEN-1:0]   wdata_nxt;

  logic [XLEN-1:0]   dp_result;
  logic              dp_illegal;

  switch_mcu_alu_imm_dp #(
    .XLEN  (XLEN),
    .IMM_W (IMM_W),
    .SHW   (SHW)
  ) u_dp (
    .funct3  (funct3_q),
    .imm     (imm_q),
    .rs1_val (in_rdata_1),
    .result  (dp_result),
    .illegal (dp_illegal)
  );

  // Next-state and next-output decode; every output defaults to zero so
  // pulses last exactly one cycle and an abort clears everything.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    funct3_nxt  = funct3_q;
    imm_nxt     = imm_q;
    rd_nxt      = rd_q;
    raddr_nxt   = '0;
    ren_nxt     = 1'b0;
    waddr_nxt   = '0;
    wen_nxt     = 1'b0;
    wdata_nxt   = '0;
    busy_nxt    = 1'b0;
    done_nxt    = 1'b0;
    illegal_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (in_en) begin
          funct3_nxt = in_funct3;
          imm_nxt    = in_imm_type_i;
          rd_nxt     = in_rd;
          raddr_nxt  = in_rs1;
          ren_nxt    = 1'b1;
          busy_nxt   = 1'b1;
          state_nxt  = READ;
        end
      end
      READ: begin
        if (!in_en) begin
          state_nxt = IDLE;
        end else begin
          busy_nxt  = 1'b1;
          cnt_nxt   = CNT_W'(RD_LAT - 1);
          state_nxt = (RD_LAT == 1) ? EXEC : WAIT;
        end
      end
      WAIT: begin
        if (!in_en) begin
          state_nxt = IDLE;
        end else begin
          busy_nxt = 1'b1;
          cnt_nxt  = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state_nxt = EXEC;
          end
        end
      end
      EXEC: begin
        state_nxt = IDLE;
        if (in_en) begin
          done_nxt    = 1'b1;
          illegal_nxt = dp_illegal;
          wen_nxt     = !dp_illegal && (rd_q != '0);
          waddr_nxt   = rd_q;
          wdata_nxt   = dp_result;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sequencer state, wait counter and latched operand fields
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      funct3_q <= '0;
      imm_q    <= '0;
      rd_q     <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      funct3_q <= funct3_nxt;
      imm_q    <= imm_nxt;
      rd_q     <= rd_nxt;
    end
  end

  // Registered outputs towards the register file and the decoder
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      out_raddr_1 <= '0;
      out_ren_1   <= 1'b0;
      out_waddr   <= '0;
      out_wen     <= 1'b0;
      out_wdata   <= '0;
      out_busy    <= 1'b0;
      out_done    <= 1'b0;
      out_illegal <= 1'b0;
    end else begin
      out_raddr_1 <= raddr_nxt;
      out_ren_1   <= ren_nxt;
      out_waddr   <= waddr_nxt;
      out_wen     <= wen_nxt;
      out_wdata   <= wdata_nxt;
      out_busy    <= busy_nxt;
      out_done    <= done_nxt;
      out_illegal <= illegal_nxt;
    end
  end

endmodule

// File: tb/tb_switch_mcu_alu_imm.sv
// Bench for switch_mcu_alu_imm: four instances with read latencies 1..4
// run the same ops side by side against a behavioural reference model.
module tb_switch_mcu_alu_imm;

  localparam int NI = 4;
  localparam int NE = 8;

  // Snapshot layout: {ren, raddr, busy, wen, waddr, wdata, done, illegal}
  typedef logic [46:0] snap_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [NI-1:0] en;
  logic [2:0]    funct3;
  logic [11:0]   imm;
  logic [4:0]    rs1, rd;
  logic [31:0]   rdata [NI];
  logic [4:0]    raddr [NI];
  logic [4:0]    waddr [NI];
  logic [31:0]   wdata [NI];
  logic [NI-1:0] ren, wen, busy, done, illegal;

  int vectors = 0;
  int miscompares = 0;

  snap_t obs   [NI][NE+1];
  snap_t exp_s [NI][NE+1];
  snap_t msk   [NI][NE+1];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    switch_mcu_alu_imm #(
      .XLEN   (32),
      .REG_AW (5),
      .IMM_W  (12),
      .RD_LAT (g + 1)
    ) u_dut (
      .in_clk        (clk),
      .in_rst        (rst_n),
      .in_en         (en[g]),
      .in_funct3     (funct3),
      .in_imm_type_i (imm),
      .in_rs1        (rs1),
      .in_rd         (rd),
      .in_rdata_1    (rdata[g]),
      .out_raddr_1   (raddr[g]),
      .out_ren_1     (ren[g]),
      .out_waddr     (waddr[g]),
      .out_wen       (wen[g]),
      .out_wdata     (wdata[g]),
      .out_busy      (busy[g]),
      .out_done      (done[g]),
      .out_illegal   (illegal[g])
    );
  end

  function automatic snap_t snap(input int i);
    return {ren[i], raddr[i], busy[i], wen[i], waddr[i], wdata[i], done[i], illegal[i]};
  endfunction

  // Reference result from the instruction semantics
  function automatic logic [31:0] model_result(input logic [2:0] f3, input logic [11:0] im,
                                               input logic [31:0] a);
    logic [31:0] sx, fill, r;
    int sh;
    sx   = {{20{im[11]}}, im};
    sh   = int'(im[4:0]);
    fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
    case (f3)
      3'd0:    r = a + sx;
      3'd1:    r = a << sh;
      3'd2:    r = (int'(a) < int'(sx)) ? 32'd1 : 32'd0;
      3'd3:    r = (a < sx) ? 32'd1 : 32'd0;
      3'd4:    r = a ^ sx;
      3'd6:    r = a | sx;
      3'd7:    r = a & sx;
      default: r = im[10] ? ((a >> sh) | fill) : (a >> sh);
    endcase
    return r;
  endfunction

  function automatic logic model_illegal(input logic [2:0] f3, input logic [11:0] im);
    return ((f3 == 3'd1) && (im[11:5] != 7'h00)) ||
           ((f3 == 3'd5) && (im[11:5] != 7'h00) && (im[11:5] != 7'h20));
  endfunction

  // Runs one op on all instances, recording observed and predicted
  // snapshots after each edge. abort_at = edge that first sees in_en low.
  task automatic run_op(input logic [2:0] f3, input logic [11:0] im, input logic [4:0] r1,
                        input logic [4:0] rdd, input logic [31:0] val, input int abort_at);
    int d [NI];
    int e;
    logic [31:0] res;
    logic ill, fin;
    res = model_result(f3, im, val);
    ill = model_illegal(f3, im);
    for (int i = 0; i < NI; i++) begin
      e = i + 3;
      d[i] = (abort_at == 0 || abort_at > e) ? e + 1 : abort_at;
      rdata[i] = $urandom;
    end
    funct3 = f3;
    imm    = im;
    rs1    = r1;
    rd     = rdd;
    en     = '1;
    for (int n = 1; n <= NE; n++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        e = i + 3;
        fin = (n == e) && (d[i] > e);
        obs[i][n]   = snap(i);
        exp_s[i][n] = {(n == 1), ((n == 1) ? r1 : 5'd0), ((n < e) && (n < d[i])),
                       (fin && !ill && (rdd != 5'd0)), (fin ? rdd : 5'd0),
                       (fin ? res : 32'd0), fin, (fin && ill)};
        msk[i][n]   = (fin && ill) ? {1'b1, 5'h1F, 1'b1, 1'b1, 5'h00, 32'h0, 1'b1, 1'b1}
                                   : {47{1'b1}};
        en[i]    = (n + 1 < d[i]);
        rdata[i] = (n == i + 2) ? val : $urandom;
      end
      funct3 = 3'($urandom);
      imm    = 12'($urandom);
      rs1    = 5'($urandom);
      rd     = 5'($urandom);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    en    = '0;
    #1;
    for (int i = 0; i < NI; i++) begin
      vectors++;
      if (snap(i) !== 47'd0) begin
        miscompares++;
        $display("[TB] FAIL reset lat=%0d got=%h exp=0", i + 1, snap(i));
      end
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_andi;
    run_op(3'b111, 12'hF0F, 5'd5, 5'd7, 32'h0000_FFF0, 0);
    for (int i = 0; i < NI; i++)
      for (int n = 1; n <= NE; n++) begin
        vectors++;
        if ((obs[i][n] & msk[i][n]) !== (exp_s[i][n] & msk[i][n])) begin
          miscompares++;
          $display("[TB] FAIL andi lat=%0d edge=%0d got=%h exp=%h", i + 1, n, obs[i][n], exp_s[i][n]);
        end
      end
    vectors++;
    if (obs[0][1][46:41] !== {1'b1, 5'd5}) begin
      miscompares++;
      $display("[TB] FAIL andi_read got=%h exp=%h", obs[0][1][46:41], {1'b1, 5'd5});
    end
    vectors++;
    if (obs[0][3][39:2] !== {1'b1, 5'd7, 32'h0000_FF00}) begin
      miscompares++;
      $display("[TB] FAIL andi_write got=%h exp=%h", obs[0][3][39:2], {1'b1, 5'd7, 32'h0000_FF00});
    end
    vectors++;
    if (obs[3][6][39] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL lat4_wen_edge6 got=%b exp=1", obs[3][6][39]);
    end
  endtask

  task automatic test_slt;
    logic [2:0]  f3s  [3] = '{3'b010, 3'b011, 3'b011};
    logic [11:0] imms [3] = '{12'h001, 12'h001, 12'hFFF};
    logic [31:0] vals [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
    logic [31:0] want [3] = '{32'd1, 32'd0, 32'd1};
    for (int k = 0; k < 3; k++) begin
      run_op(f3s[k], imms[k], 5'd2, 5'd1, vals[k], 0);
      for (int i = 0; i < NI; i++)
        for (int n = 1; n <= NE; n++) begin
          vectors++;
          if ((obs[i][n] & msk[i][n]) !== (exp_s[i][n] & msk[i][n])) begin
            miscompares++;
            $display("[TB] FAIL slt%0d lat=%0d edge=%0d got=%h exp=%h", k, i + 1, n, obs[i][n], exp_s[i][n]);
          end
        end
      vectors++;
      if (obs[1][4][33:2] !== want[k]) begin
        miscompares++;
        $display("[TB] FAIL slt%0d_value got=%h exp=%h", k, obs[1][4][33:2], want[k]);
      end
    end
  endtask

  task automatic test_shifts;
    logic [2:0]  f3s  [5] = '{3'b101, 3'b101, 3'b101, 3'b001, 3'b001};
    logic [11:0] imms [5] = '{12'h404, 12'h004, 12'h204, 12'h020, 12'h004};
    logic [31:0] vals [5] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h1, 32'h8000_0001};
    logic [31:0] want [5] = '{32'hF800_0000, 32'h0800_0000, 32'h0, 32'h0, 32'h0000_0010};
    logic        bad  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 5; k++) begin
      run_op(f3s[k], imms[k], 5'd9, 5'd12, vals[k], 0);
      for (int i = 0; i < NI; i++)
        for (int n = 1; n <= NE; n++) begin
          vectors++;
          if ((obs[i][n] & msk[i][n]) !== (exp_s[i][n] & msk[i][n])) begin
            miscompares++;
            $display("[TB] FAIL shift%0d lat=%0d edge=%0d got=%h exp=%h", k, i + 1, n, obs[i][n], exp_s[i][n]);
          end
        end
      vectors++;
      if ({obs[0][3][39], obs[0][3][1:0]} !== {!bad[k], 1'b1, bad[k]}) begin
        miscompares++;
        $display("[TB] FAIL shift%0d_flags got=%b exp=%b", k, {obs[0][3][39], obs[0][3][1:0]}, {!bad[k], 1'b1, bad[k]});
      end
      if (!bad[k]) begin
        vectors++;
        if (obs[0][3][33:2] !== want[k]) begin
          miscompares++;
          $display("[TB] FAIL shift%0d_value got=%h exp=%h", k, obs[0][3][33:2], want[k]);
        end
      end
    end
  endtask

  task automatic test_addi_rd0;
    logic [4:0] rds [2] = '{5'd0, 5'd3};
    for (int k = 0; k < 2; k++) begin
      run_op(3'b000, 12'h001, 5'd4, rds[k], 32'h7FFF_FFFF, 0);
      for (int i = 0; i < NI; i++)
        for (int n = 1; n <= NE; n++) begin
          vectors++;
          if ((obs[i][n] & msk[i][n]) !== (exp_s[i][n] & msk[i][n])) begin
            miscompares++;
            $display("[TB] FAIL addi%0d lat=%0d edge=%0d got=%h exp=%h", k, i + 1, n, obs[i][n], exp_s[i][n]);
          end
        end
      vectors++;
      if ({obs[0][3][39], obs[0][3][33:2], obs[0][3][1]} !== {(k == 1), 32'h8000_0000, 1'b1}) begin
        miscompares++;
        $display("[TB] FAIL addi%0d_write got=%h exp=%h", k,
                 {obs[0][3][39], obs[0][3][33:2], obs[0][3][1]}, {(k == 1), 32'h8000_0000, 1'b1});
      end
    end
  endtask

  task automatic test_abort;
    for (int a = 2; a <= 5; a++) begin
      run_op(3'b110, 12'h0F0, 5'd6, 5'd8, 32'h1234_5678, a);
      for (int i = 0; i < NI; i++)
        for (int n = 1; n <= NE; n++) begin
          vectors++;
          if ((obs[i][n] & msk[i][n]) !== (exp_s[i][n] & msk[i][n])) begin
            miscompares++;
            $display("[TB] FAIL abort%0d lat=%0d edge=%0d got=%h exp=%h", a, i + 1, n, obs[i][n], exp_s[i][n]);
          end
        end
      if (a == 3) begin
        vectors++;
        if ({obs[1][3][40], obs[1][4][39], obs[1][4][1]} !== 3'b000) begin
          miscompares++;
          $display("[TB] FAIL abort_wait got=%b exp=000", {obs[1][3][40], obs[1][4][39], obs[1][4][1]});
        end
      end
    end
  endtask

  task automatic test_reset_mid_wait;
    funct3 = 3'b000;
    imm    = 12'h010;
    rs1    = 5'd2;
    rd     = 5'd4;
    en     = '1;
    for (int i = 0; i < NI; i++) rdata[i] = $urandom;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (busy[2] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midwait_busy got=%b exp=1", busy[2]);
    end
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      vectors++;
      if (snap(i) !== 47'd0) begin
        miscompares++;
        $display("[TB] FAIL midwait_reset lat=%0d got=%h exp=0", i + 1, snap(i));
      end
    end
    en = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'b100, 12'h0FF, 5'd11, 5'd13, 32'hA5A5_0F0F, 0);
    for (int i = 0; i < NI; i++)
      for (int n = 1; n <= NE; n++) begin
        vectors++;
        if ((obs[i][n] & msk[i][n]) !== (exp_s[i][n] & msk[i][n])) begin
          miscompares++;
          $display("[TB] FAIL after_reset lat=%0d edge=%0d got=%h exp=%h", i + 1, n, obs[i][n], exp_s[i][n]);
        end
      end
  endtask

  task automatic test_back_to_back;
    logic [2:0] want;
    funct3   = 3'b000;
    imm      = 12'h001;
    rs1      = 5'd3;
    rd       = 5'd9;
    rdata[0] = 32'd5;
    en       = 4'b0001;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk);
      #1;
      want = {(n == 1 || n == 4), (n == 1 || n == 2 || n == 4 || n == 5), (n == 3 || n == 6)};
      vectors++;
      if ({ren[0], busy[0], done[0]} !== want) begin
        miscompares++;
        $display("[TB] FAIL b2b edge=%0d got=%b exp=%b", n, {ren[0], busy[0], done[0]}, want);
      end
      if (n == 3 || n == 6) begin
        vectors++;
        if (wdata[0] !== 32'd6) begin
          miscompares++;
          $display("[TB] FAIL b2b_value edge=%0d got=%h exp=%h", n, wdata[0], 32'd6);
        end
      end
    end
    en = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random;
    logic [2:0]  f3;
    logic [11:0] im;
    int          ab;
    for (int k = 0; k < 16; k++) begin
      f3 = 3'($urandom_range(0, 7));
      im = 12'($urandom);
      if ((f3 == 3'd1 || f3 == 3'd5) && $urandom_range(0, 3) != 0)
        im[11:5] = (f3 == 3'd5 && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 7)) : 0;
      run_op(f3, im, 5'($urandom), 5'($urandom), $urandom, ab);
      for (int i = 0; i < NI; i++)
        for (int n = 1; n <= NE; n++) begin
          vectors++;
          if ((obs[i][n] & msk[i][n]) !== (exp_s[i][n] & msk[i][n])) begin
            miscompares++;
            $display("[TB] FAIL random%0d f3=%0d imm=%h lat=%0d edge=%0d got=%h exp=%h",
                     k, f3, im, i + 1, n, obs[i][n], exp_s[i][n]);
          end
        end
    end
  endtask

  initial begin
    en     = '0;
    funct3 = '0;
    imm    = '0;
    rs1    = '0;
    rd     = '0;
    for (int i = 0; i < NI; i++) rdata[i] = '0;
    test_reset;
    test_andi;
    test_slt;
    test_shifts;
    test_addi_rd0;
    test_abort;
    test_back_to_back;
    test_reset_mid_wait;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
